// File: rtl/pe_pkg.sv
// Shared types and arithmetic helpers for the streaming accumulate-and-requantise PE.
// Saturation is done in a fixed wide domain so callers can narrow the result with a cast.
package pe_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_OUT  = 2'd2
  } pe_state_e;

  localparam int DEF_DW = 8;
  localparam int PROD_W = 2 * DEF_DW;
  localparam int WIDE_W = 64;

  // Width of a full-precision sum of n products of two dw-bit signed values.
  function automatic int dot_w(input int dw, input int n);
    return 2 * dw + $clog2(n);
  endfunction

  function automatic logic signed [WIDE_W-1:0] sat_to(input logic signed [WIDE_W-1:0] x,
                                                      input int w);
    logic signed [WIDE_W-1:0] one;
    logic signed [WIDE_W-1:0] hi;
    logic signed [WIDE_W-1:0] lo;
    logic signed [WIDE_W-1:0] res;
    one = WIDE_W'(1);
    hi  = (one <<< (w - 1)) - one;
    lo  = ~hi;
    if (x > hi) begin
      res = hi;
    end else if (x < lo) begin
      res = lo;
    end else begin
      res = x;
    end
    return res;
  endfunction

  function automatic logic signed [WIDE_W-1:0] sat_acc(input logic signed [WIDE_W-1:0] x,
                                                       input int acc_w);
    return sat_to(x, acc_w);
  endfunction

  function automatic logic signed [WIDE_W-1:0] sat_dw(input logic signed [WIDE_W-1:0] x,
                                                      input int dw);
    return sat_to(x, dw);
  endfunction

endpackage

// File: rtl/pe_dot_masked.sv
// Combinational masked dot product of a pixel window against the weight tile.
// Only positions with row < K and column < K contribute.
module pe_dot_masked
  import pe_pkg::*;
#(
  parameter int DW    = 8,
  parameter int ROWS  = 6,
  parameter int COLS  = 6,
  parameter int K_W   = 4,
  parameter int DOT_W = dot_w(DW, ROWS * COLS)
) (
  input  logic [ROWS*COLS*DW-1:0] i_img,
  input  logic [ROWS*COLS*DW-1:0] i_tile,
  input  logic [K_W-1:0]          i_k,
  output logic signed [DOT_W-1:0] o_dot
);

  localparam int P_W = 2 * DW;

  logic signed [DOT_W-1:0] w_sum;
  logic signed [DW-1:0]    w_px;
  logic signed [DW-1:0]    w_wt;
  logic signed [P_W-1:0]   w_prod;
  logic signed [DOT_W-1:0] w_prod_x;
  int                      w_k_i;

  always_comb begin
    w_sum    = '0;
    w_px     = '0;
    w_wt     = '0;
    w_prod   = '0;
    w_prod_x = '0;
    w_k_i    = int'(i_k);
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if ((r < w_k_i) && (c < w_k_i)) begin
          w_px     = i_img[(r*COLS+c)*DW +: DW];
          w_wt     = i_tile[(r*COLS+c)*DW +: DW];
          w_prod   = w_px * w_wt;
          w_prod_x = w_prod;
          w_sum    = w_sum + w_prod_x;
        end
      end
    end
  end

  assign o_dot = w_sum;

endmodule

// File: rtl/pe_acc_stream.sv
// Streaming PE: masked dot product per beat, saturating accumulation across beats,
// then shift/saturate/ReLU requantisation presented on a valid/ready output.
module pe_acc_stream
  import pe_pkg::*;
#(
  parameter int DW    = 8,
  parameter int ROWS  = 6,
  parameter int COLS  = 6,
  parameter int ACC_W = 24,
  parameter int SH_W  = 4,
  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int MAX_RC = (ROWS > COLS) ? ROWS : COLS,
  localparam int MIN_RC = (ROWS < COLS) ? ROWS : COLS,
  localparam int K_W    = $clog2(MAX_RC) + 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_wgt_wr_en,
  input  logic [ROW_W-1:0]          i_wgt_wr_row,
  input  logic [COLS*DW-1:0]        i_wgt_wr_data,
  input  logic signed [DW-1:0]      i_bias,
  input  logic [K_W-1:0]            i_ksize,
  input  logic [SH_W-1:0]           i_out_shift,
  input  logic                      i_relu,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [ROWS*COLS*DW-1:0]   i_img,
  input  logic                      i_last,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic signed [DW-1:0]      o_result,
  output logic                      o_busy
);

  localparam int DOT_W = dot_w(DW, ROWS * COLS);

  // Handshake: a transfer happens on a clock edge where valid && ready are both high.
  // Valid never waits on ready, and o_ready depends on state only (no path from i_ready).

  pe_state_e                  r_state;
  pe_state_e                  w_state_nxt;
  logic [ROWS*COLS*DW-1:0]    r_tile;
  logic signed [ACC_W-1:0]    r_acc;
  logic signed [ACC_W-1:0]    w_acc_nxt;
  logic [K_W-1:0]             r_k;
  logic [SH_W-1:0]            r_shift;
  logic                       r_relu;
  logic [K_W-1:0]             w_k_in;
  logic [K_W-1:0]             w_k_use;
  logic                       w_beat;
  logic signed [DOT_W-1:0]    w_dot;
  logic signed [WIDE_W-1:0]   w_acc_x;
  logic signed [WIDE_W-1:0]   w_dot_x;
  logic signed [WIDE_W-1:0]   w_bias_x;
  logic signed [ACC_W-1:0]    w_q_s;
  logic signed [WIDE_W-1:0]   w_q_x;
  logic signed [DW-1:0]       w_q;

  assign o_ready = (r_state != S_OUT);
  assign o_valid = (r_state == S_OUT);
  assign o_busy  = (r_state != S_IDLE);
  assign w_beat  = i_valid && o_ready;

  // Out-of-range K selects the largest square that fits the tile.
  assign w_k_in  = ((i_ksize == '0) || (int'(i_ksize) > MIN_RC)) ? K_W'(MIN_RC) : i_ksize;
  assign w_k_use = (r_state == S_IDLE) ? w_k_in : r_k;

  pe_dot_masked #(
    .DW    (DW),
    .ROWS  (ROWS),
    .COLS  (COLS),
    .K_W   (K_W),
    .DOT_W (DOT_W)
  ) u_dot (
    .i_img  (i_img),
    .i_tile (r_tile),
    .i_k    (w_k_use),
    .o_dot  (w_dot)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_beat) w_state_nxt = i_last ? S_OUT : S_ACC;
      S_ACC:  if (w_beat && i_last) w_state_nxt = S_OUT;
      S_OUT:  if (i_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_acc_x   = r_acc;
    w_dot_x   = w_dot;
    w_bias_x  = i_bias;
    w_acc_nxt = r_acc;
    case (r_state)
      S_IDLE: begin
        if (w_beat) begin
          w_acc_nxt = ACC_W'(sat_acc((w_bias_x <<< i_out_shift) + w_dot_x, ACC_W));
        end
      end
      S_ACC: begin
        if (w_beat) begin
          w_acc_nxt = ACC_W'(sat_acc(w_acc_x + w_dot_x, ACC_W));
        end
      end
      S_OUT: begin
        if (i_ready) w_acc_nxt = '0;
      end
      default: w_acc_nxt = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc   <= '0;
      r_k     <= '0;
      r_shift <= '0;
      r_relu  <= 1'b0;
    end else begin
      r_acc <= w_acc_nxt;
      if ((r_state == S_IDLE) && w_beat) begin
        r_k     <= w_k_in;
        r_shift <= i_out_shift;
        r_relu  <= i_relu;
      end
    end
  end

  // Tile writes only land while idle so an in-flight job keeps a consistent tile.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tile <= '0;
    end else if (i_wgt_wr_en && (r_state == S_IDLE) && (int'(i_wgt_wr_row) < ROWS)) begin
      r_tile[int'(i_wgt_wr_row)*COLS*DW +: COLS*DW] <= i_wgt_wr_data;
    end
  end

  always_comb begin
    w_q_s = r_acc >>> r_shift;
    w_q_x = w_q_s;
    w_q   = DW'(sat_dw(w_q_x, DW));
    if (r_relu && w_q_s[ACC_W-1]) w_q = '0;
  end

  assign o_result = (r_state == S_OUT) ? w_q : '0;

endmodule

// File: tb/tb_pe_acc_stream.sv
// Directed bench for pe_acc_stream: masking, multi-beat accumulation, saturation,
// backpressure, weight-write gating and mid-job reset.
module tb_pe_acc_stream;

  localparam int DW    = 8;
  localparam int ROWS  = 6;
  localparam int COLS  = 6;
  localparam int ACC_W = 24;
  localparam int SH_W  = 4;
  localparam int ROW_W = 3;
  localparam int K_W   = 4;

  logic                    i_clk;
  logic                    i_rst_n;
  logic                    i_wgt_wr_en;
  logic [ROW_W-1:0]        i_wgt_wr_row;
  logic [COLS*DW-1:0]      i_wgt_wr_data;
  logic signed [DW-1:0]    i_bias;
  logic [K_W-1:0]          i_ksize;
  logic [SH_W-1:0]         i_out_shift;
  logic                    i_relu;
  logic                    i_valid;
  logic                    o_ready;
  logic [ROWS*COLS*DW-1:0] i_img;
  logic                    i_last;
  logic                    o_valid;
  logic                    i_ready;
  logic signed [DW-1:0]    o_result;
  logic                    o_busy;

  int checks = 0;
  int errors = 0;

  pe_acc_stream #(
    .DW(DW), .ROWS(ROWS), .COLS(COLS), .ACC_W(ACC_W), .SH_W(SH_W)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_wgt_wr_en(i_wgt_wr_en), .i_wgt_wr_row(i_wgt_wr_row), .i_wgt_wr_data(i_wgt_wr_data),
    .i_bias(i_bias), .i_ksize(i_ksize), .i_out_shift(i_out_shift), .i_relu(i_relu),
    .i_valid(i_valid), .o_ready(o_ready), .i_img(i_img), .i_last(i_last),
    .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result), .o_busy(o_busy)
  );

  // Clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wr_row(input int row, input logic [COLS*DW-1:0] data);
    i_wgt_wr_en   = 1'b1;
    i_wgt_wr_row  = ROW_W'(row);
    i_wgt_wr_data = data;
    step();
    i_wgt_wr_en   = 1'b0;
  endtask

  task automatic set_tile(input logic [DW-1:0] v);
    for (int r = 0; r < ROWS; r++) wr_row(r, {COLS{v}});
  endtask

  task automatic set_img(input logic [DW-1:0] v);
    i_img = {(ROWS*COLS){v}};
  endtask

  task automatic send_beat(input logic last);
    int n;
    n = 0;
    i_valid = 1'b1;
    i_last  = last;
    while (!o_ready && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (!o_ready) begin
      errors++;
      $display("FAIL beat_timeout o_ready=%0b after %0d cycles, required 1", o_ready, n);
    end
    step();
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic pop();
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
  endtask

  // Scenarios
  task automatic test_reset();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b exp 0", o_valid); end
    checks++; if (o_result !== 8'sd0) begin errors++; $display("FAIL rst_result got %0d exp 0", o_result); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b exp 0", o_busy); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %0b exp 1", o_ready); end
  endtask

  task automatic test_k3_mask();
    set_tile(8'sd1);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        i_img[(r*COLS+c)*DW +: DW] = (r < 3 && c < 3) ? 8'sd2 : 8'sd9;
    i_ksize = 4'd3; i_bias = 8'sd0; i_out_shift = 4'd0; i_relu = 1'b0;
    send_beat(1'b1);
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL k3_valid got %0b exp 1", o_valid); end
    checks++; if (o_result !== 8'sd18) begin errors++; $display("FAIL k3_result got %0d exp 18", o_result); end
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL k3_ready got %0b exp 0", o_ready); end
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL k3_busy got %0b exp 1", o_busy); end
    pop();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL k3_pop_valid got %0b exp 0", o_valid); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL k3_pop_busy got %0b exp 0", o_busy); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL k3_pop_ready got %0b exp 1", o_ready); end
  endtask

  task automatic test_multi_beat();
    set_img(8'sd10);
    i_ksize = 4'd1; i_bias = 8'sd5; i_out_shift = 4'd1; i_relu = 1'b0;
    for (int b = 0; b < 3; b++) begin
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL multi_ready beat %0d got %0b exp 1", b, o_ready); end
      send_beat(b == 2);
      // Config changes mid-job must be ignored
      i_bias = 8'sd100; i_out_shift = 4'd0; i_ksize = 4'd6;
    end
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL multi_valid got %0b exp 1", o_valid); end
    checks++; if (o_result !== 8'sd20) begin errors++; $display("FAIL multi_result got %0d exp 20", o_result); end
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL multi_ready_out got %0b exp 0", o_ready); end
    pop();
  endtask

  task automatic test_floor_shift();
    set_img(-8'sd3);
    i_ksize = 4'd1; i_bias = 8'sd0; i_out_shift = 4'd1; i_relu = 1'b0;
    send_beat(1'b1);
    checks++; if (o_result !== -8'sd2) begin errors++; $display("FAIL floor_result got %0d exp -2", o_result); end
    pop();
  endtask

  task automatic test_saturation();
    set_tile(8'sd127);
    i_bias = 8'sd0; i_out_shift = 4'd0; i_relu = 1'b0;
    i_ksize = 4'd6; set_img(8'sd127);
    send_beat(1'b1);
    checks++; if (o_result !== 8'sd127) begin errors++; $display("FAIL sat_pos got %0d exp 127", o_result); end
    pop();
    i_ksize = 4'd0; set_img(8'h80);
    send_beat(1'b1);
    checks++; if (o_result !== -8'sd128) begin errors++; $display("FAIL sat_neg_k0 got %0d exp -128", o_result); end
    pop();
    i_ksize = 4'd9; i_relu = 1'b1;
    send_beat(1'b1);
    checks++; if (o_result !== 8'sd0) begin errors++; $display("FAIL sat_relu got %0d exp 0", o_result); end
    pop();
    // 15 beats of -585216 overflow 24 bits; clamped acc >>> 15 stays negative
    i_ksize = 4'd6; i_relu = 1'b0; i_out_shift = 4'd15;
    for (int b = 0; b < 15; b++) send_beat(b == 14);
    checks++; if (o_result !== -8'sd128) begin errors++; $display("FAIL sat_acc_clamp got %0d exp -128", o_result); end
    pop();
  endtask

  task automatic test_backpressure();
    set_tile(8'sd1);
    set_img(8'sd3);
    i_ksize = 4'd2; i_bias = 8'sd1; i_out_shift = 4'd0; i_relu = 1'b0;
    send_beat(1'b1);
    i_bias = 8'sd0;
    i_valid = 1'b1; i_last = 1'b1; i_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL bp_ready cyc %0d got %0b exp 0", n, o_ready); end
      checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL bp_valid cyc %0d got %0b exp 1", n, o_valid); end
      checks++; if (o_result !== 8'sd13) begin errors++; $display("FAIL bp_result cyc %0d got %0d exp 13", n, o_result); end
      step();
    end
    pop();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %0b exp 0", o_valid); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %0b exp 1", o_ready); end
    step();
    i_valid = 1'b0; i_last = 1'b0;
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL bp_next_valid got %0b exp 1", o_valid); end
    checks++; if (o_result !== 8'sd12) begin errors++; $display("FAIL bp_next_result got %0d exp 12", o_result); end
    pop();
  endtask

  task automatic test_weight_write();
    logic [COLS*DW-1:0] row5;
    logic [COLS*DW-1:0] row2;
    row5 = {{(COLS-1){8'sd1}}, 8'sd5};
    row2 = {{(COLS-1){8'sd1}}, 8'sd2};
    set_img(8'sd10);
    i_ksize = 4'd1; i_bias = 8'sd0; i_out_shift = 4'd0; i_relu = 1'b0;
    send_beat(1'b0);
    wr_row(0, row5);
    send_beat(1'b1);
    checks++; if (o_result !== 8'sd20) begin errors++; $display("FAIL ww_acc_job got %0d exp 20", o_result); end
    pop();
    send_beat(1'b1);
    checks++; if (o_result !== 8'sd10) begin errors++; $display("FAIL ww_dropped got %0d exp 10", o_result); end
    pop();
    wr_row(0, row5);
    send_beat(1'b1);
    checks++; if (o_result !== 8'sd50) begin errors++; $display("FAIL ww_idle_write got %0d exp 50", o_result); end
    pop();
    // Write and accept together: the beat sees the old tile
    i_wgt_wr_en = 1'b1; i_wgt_wr_row = 3'd0; i_wgt_wr_data = row2;
    i_valid = 1'b1; i_last = 1'b1;
    step();
    i_wgt_wr_en = 1'b0; i_valid = 1'b0; i_last = 1'b0;
    checks++; if (o_result !== 8'sd50) begin errors++; $display("FAIL ww_same_cycle got %0d exp 50", o_result); end
    pop();
    send_beat(1'b1);
    checks++; if (o_result !== 8'sd20) begin errors++; $display("FAIL ww_after_same got %0d exp 20", o_result); end
    pop();
  endtask

  task automatic test_reset_mid_job();
    set_img(8'sd10);
    i_ksize = 4'd1; i_bias = 8'sd0; i_out_shift = 4'd0; i_relu = 1'b0;
    send_beat(1'b0);
    send_beat(1'b0);
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_pre got %0b exp 1", o_busy); end
    i_rst_n = 1'b0;
    #1;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %0b exp 0", o_busy); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %0b exp 0", o_valid); end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    step();
    i_ksize = 4'd6; i_bias = 8'sd3; i_out_shift = 4'd0;
    send_beat(1'b1);
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL rmid_new_valid got %0b exp 1", o_valid); end
    checks++; if (o_result !== 8'sd3) begin errors++; $display("FAIL rmid_new_result got %0d exp 3", o_result); end
    pop();
  endtask

  initial begin
    i_rst_n = 1'b0; i_wgt_wr_en = 1'b0; i_wgt_wr_row = '0; i_wgt_wr_data = '0;
    i_bias = '0; i_ksize = '0; i_out_shift = '0; i_relu = 1'b0;
    i_valid = 1'b0; i_img = '0; i_last = 1'b0; i_ready = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    step();
    test_reset();
    test_k3_mask();
    test_multi_beat();
    test_floor_shift();
    test_saturation();
    test_backpressure();
    test_weight_write();
    test_reset_mid_job();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
